// File: rtl/priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : priority_arbiter
//  Description : 8-requester arbiter with a three-state FSM (IDLE, GRANT,
//                RELEASE). In IDLE the winner is chosen by one of two rules.
//                Fixed mode gives the grant to the highest-indexed request.
//                Round-robin mode searches downward from (last_id - 1) and
//                wraps from 0 to 7. A grant is held until the owner pulses
//                done, the owner drops its request, or MAX_HOLD cycles pass.
//                A release at MAX_HOLD with no other cause raises a one-cycle
//                timeout pulse in RELEASE.
//  Ports       : clk         - single clock, rising edge
//                rst         - synchronous active-high reset
//                req[7:0]    - request lines, bit n = requester n
//                done        - owner's release pulse (ignored unless granted)
//                rr_mode     - 0 fixed priority, 1 round-robin (IDLE only)
//                grant[7:0]  - registered one-hot grant
//                grant_id    - binary index of the granted requester
//                grant_valid - high while grant is non-zero
//                timeout     - one-cycle pulse after a forced release
//  Revision    : 1.0 - initial release
// ============================================================================
module priority_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    input  logic       rr_mode,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [7:0] C_MAX_HOLD = 8'(MAX_HOLD);

    logic [1:0] r_state;
    logic [7:0] r_hold;
    logic [2:0] r_last_id;

    logic [2:0] w_fixed_id;
    logic [2:0] w_rr_id;
    logic       w_rr_found;
    logic [2:0] w_idx;
    logic [2:0] w_win_id;
    logic       w_owner_req;
    logic       w_hold_max;
    logic       w_end;
    logic       w_forced;

    // Fixed priority: ascending scan, so the last asserted bit (highest) wins.
    always_comb begin
        w_fixed_id = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                w_fixed_id = 3'(i);
            end
        end
    end

    // Round-robin: probe last_id-1, last_id-2, ... down to last_id itself.
    // The 3-bit subtraction wraps 0 -> 7, and the eighth probe lands back on
    // last_id so a lone requester is granted again.
    always_comb begin
        w_rr_id    = 3'd0;
        w_rr_found = 1'b0;
        w_idx      = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            w_idx = r_last_id - 3'(k);
            if (!w_rr_found && req[w_idx]) begin
                w_rr_id    = w_idx;
                w_rr_found = 1'b1;
            end
        end
    end

    assign w_win_id    = rr_mode ? w_rr_id : w_fixed_id;
    assign w_owner_req = req[grant_id];
    assign w_hold_max  = (r_hold == C_MAX_HOLD);
    assign w_end       = done | ~w_owner_req | w_hold_max;
    // A release at the hold limit is only "forced" if nothing else caused it.
    assign w_forced    = w_hold_max & ~done & w_owner_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hold      <= 8'd0;
            r_last_id   <= 3'd0;
            grant       <= 8'd0;
            grant_id    <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    timeout <= 1'b0;
                    if (|req) begin
                        r_state     <= S_GRANT;
                        grant       <= 8'd1 << w_win_id;
                        grant_id    <= w_win_id;
                        grant_valid <= 1'b1;
                        r_hold      <= 8'd1;
                        r_last_id   <= w_win_id;
                    end else begin
                        grant       <= 8'd0;
                        grant_id    <= 3'd0;
                        grant_valid <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (w_end) begin
                        r_state     <= S_RELEASE;
                        grant       <= 8'd0;
                        grant_valid <= 1'b0;
                        timeout     <= w_forced;
                        r_hold      <= 8'd0;
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                S_RELEASE: begin
                    // grant_id stays visible through RELEASE, clears in IDLE.
                    r_state  <= S_IDLE;
                    timeout  <= 1'b0;
                    grant_id <= 3'd0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    grant       <= 8'd0;
                    grant_id    <= 3'd0;
                    grant_valid <= 1'b0;
                    timeout     <= 1'b0;
                    r_hold      <= 8'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_priority_arbiter
//  Description : Self-checking bench for priority_arbiter. An owner/age
//                model predicts the outputs every cycle. Directed scenarios
//                pin the model with literal expectations before a randomized
//                phase runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_arbiter;

    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       rr_mode;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    priority_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .rr_mode    (rr_mode),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       m_owner = -1;   // current owner, -1 when nobody holds a grant
    int       m_age   = 0;    // cycles the owner has held the grant so far
    int       m_last  = 0;
    bit       m_rel   = 0;    // in the single gap cycle after a grant
    logic [7:0] e_grant = 0;
    int       e_id    = 0;
    bit       e_valid = 0;
    bit       e_to    = 0;

    function automatic int pick(input logic [7:0] r, input logic rr, input int last);
        if (!rr) begin
            for (int i = 7; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                int idx;
                idx = (last + 8 - k) % 8;
                if (r[idx]) return idx;
            end
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_age = 0; m_last = 0; m_rel = 0;
            e_grant = 0; e_id = 0; e_valid = 0; e_to = 0;
        end else if (m_owner >= 0) begin
            if (done || !req[m_owner] || m_age == MAX_HOLD) begin
                e_to    = !done && req[m_owner];
                m_owner = -1;
                m_rel   = 1;
                e_grant = 0;
                e_valid = 0;
            end else begin
                m_age++;
            end
        end else if (m_rel) begin
            m_rel = 0;
            e_id  = 0;
            e_to  = 0;
        end else if (req != 0) begin
            m_owner = pick(req, rr_mode, m_last);
            m_age   = 1;
            m_last  = m_owner;
            e_id    = m_owner;
            e_grant = 8'(1 << m_owner);
            e_valid = 1;
            e_to    = 0;
        end else begin
            e_grant = 0; e_id = 0; e_valid = 0; e_to = 0;
        end
    end

    // Single compare process against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_grant",       grant,       e_grant);
            chk("model_grant_id",    grant_id,    e_id);
            chk("model_grant_valid", grant_valid, e_valid);
            chk("model_timeout",     timeout,     e_to);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        int cnt;

        rst = 1'b1; req = 8'h00; done = 1'b0; rr_mode = 1'b0;
        tick();
        tick();
        cmp_en = 1;
        chk("reset_grant",   grant,       32'h0);
        chk("reset_id",      grant_id,    32'd0);
        chk("reset_valid",   grant_valid, 32'd0);
        chk("reset_timeout", timeout,     32'd0);
        rst = 1'b0;

        // Fixed priority, re-grant to the same winner after the 2-cycle gap.
        rr_mode = 1'b0; req = 8'b0010_0101;
        tick();
        chk("fixed_grant", grant, 32'h20);
        chk("fixed_id",    grant_id, 32'd5);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("fixed_rel_valid", grant_valid, 32'd0);
        chk("fixed_rel_id",    grant_id,    32'd5);
        chk("fixed_rel_to",    timeout,     32'd0);
        tick();
        chk("fixed_idle_valid", grant_valid, 32'd0);
        tick();
        chk("fixed_regrant_id", grant_id, 32'd5);
        chk("fixed_regrant_v",  grant_valid, 32'd1);
        req = 8'h00;
        tick(); tick(); tick();

        // Round-robin rotation from reset.
        do_reset();
        rr_mode = 1'b1; req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("rr_seq%0d_id", k), grant_id, 32'(seq[k]));
            chk($sformatf("rr_seq%0d_v", k), grant_valid, 32'd1);
            done = 1'b1;
            tick();
            done = 1'b0;
            tick();
            tick();
        end
        req = 8'h00;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick(); tick();

        // Timeout with a single held request.
        do_reset();
        rr_mode = 1'b0; req = 8'h08;
        tick();
        cnt = 0;
        while (grant_valid && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("to_hold_cycles", cnt, 32'd16);
        chk("to_pulse",       timeout, 32'd1);
        chk("to_grant_zero",  grant,   32'h0);
        chk("to_id_hold",     grant_id, 32'd3);
        tick();
        chk("to_pulse_end",   timeout, 32'd0);
        tick();
        chk("to_regrant_id",  grant_id, 32'd3);
        chk("to_regrant_v",   grant_valid, 32'd1);
        req = 8'h00;
        tick(); tick(); tick();

        // Request drop on cycle 4 of the grant.
        do_reset();
        req = 8'h04;
        tick(); tick(); tick(); tick();
        chk("drop_still_held", grant_valid, 32'd1);
        req = 8'h00;
        tick();
        chk("drop_rel_valid", grant_valid, 32'd0);
        chk("drop_rel_to",    timeout,     32'd0);
        tick(); tick();

        // done on the same edge the hold count reaches MAX_HOLD.
        do_reset();
        req = 8'h04;
        tick();
        for (int i = 0; i < MAX_HOLD - 1; i++) tick();
        chk("tie_last_cycle_v", grant_valid, 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("tie_rel_valid", grant_valid, 32'd0);
        chk("tie_rel_to",    timeout,     32'd0);
        req = 8'h00;
        tick(); tick();

        // Reset in the middle of a grant, then round-robin wrap to 6.
        do_reset();
        rr_mode = 1'b0; req = 8'h40;
        tick();
        chk("mid_id6", grant_id, 32'd6);
        rst = 1'b1;
        tick();
        chk("mid_rst_grant", grant,       32'h0);
        chk("mid_rst_id",    grant_id,    32'd0);
        chk("mid_rst_valid", grant_valid, 32'd0);
        rst = 1'b0; rr_mode = 1'b1; req = 8'h40;
        tick();
        chk("mid_after_id", grant_id, 32'd6);
        chk("mid_after_g",  grant,    32'h40);

        // Randomized phase.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       req = 8'h00;
                    1:       req = 8'(1 << $urandom_range(0, 7));
                    default: req = 8'($urandom);
                endcase
            end
            done    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
            rst     = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; req = 8'h00; done = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of cycles a grant may be held before forced release (range 2..255).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  8  request lines; bit n is requester n.
REQ-005 done  input  1  current owner's release pulse; ignored unless a grant is active.
REQ-006 rr_mode  input  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE.
REQ-007 grant  output  8  one-hot registered grant vector.
REQ-008 grant_id  output  3  binary index of the granted requester.
REQ-009 grant_valid  output  1  high while grant is non-zero.
REQ-010 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, GRANT, RELEASE.
REQ-012 IDLE: if req != 0, next state SHALL be GRANT, with the winner latched into grant/grant_id and grant_valid set on the same clock edge, giving 1-cycle latency from req to grant.
REQ-013 IDLE with req == 0: state SHALL remain IDLE with grant = 0, grant_id = 0, grant_valid = 0.
REQ-014 Fixed mode: the winner SHALL be the highest-indexed asserted req bit (req[7] highest, req[0] lowest).
REQ-015 Round-robin mode: the search SHALL start at index (last_id - 1) mod 8 and proceed downward with wrap-around (0 -> 7); the first asserted bit found wins.
REQ-016 last_id SHALL be updated to grant_id at every entry to GRANT.
REQ-017 A round-robin requester that is the only one asserting SHALL be granted again after RELEASE (self wrap).
REQ-018 GRANT: an 8-bit hold counter SHALL be loaded with 1 on entry and increment each cycle in GRANT.
REQ-019 GRANT -> RELEASE SHALL occur on the first edge where any of the following holds: done = 1; req[grant_id] = 0; hold counter = MAX_HOLD.
REQ-020 Simultaneous done (or req drop) and hold counter = MAX_HOLD SHALL be treated as normal release: timeout stays 0.
REQ-021 timeout SHALL pulse high for exactly the one cycle in RELEASE that follows a forced release.
REQ-022 RELEASE: grant = 0 and grant_valid = 0 for exactly one cycle, and grant_id SHALL hold its last value; the next state SHALL be IDLE unconditionally.
REQ-023 Consequently, the minimum spacing between grants SHALL be 2 idle cycles (RELEASE + IDLE), and back-to-back grants to different requesters SHALL never overlap.
REQ-024 grant SHALL always equal 1 << grant_id when grant_valid = 1, and 0 otherwise.
REQ-025 done asserted in IDLE or RELEASE SHALL have no effect.
REQ-026 Changes on req bits other than grant_id during GRANT SHALL NOT affect the current grant.
REQ-027 rr_mode changes during GRANT or RELEASE SHALL take effect only at the next IDLE evaluation.

Reset
REQ-028 When rst = 1 at a clock edge, the following SHALL be cleared on that edge, with priority over all other transitions including mid-grant: state = IDLE, grant = 0, grant_id = 0, grant_valid = 0, timeout = 0, hold counter = 0, last_id = 0.
REQ-029 The first arbitration after reset SHALL occur on the edge following rst deassertion.

Verification
REQ-030 Fixed priority: rr_mode = 0, req = 8'b0010_0101 held -> grant = 8'b0010_0000, grant_id = 5 one cycle later; with done pulsed, the next grant after 2 idle cycles SHALL again be id 5.
REQ-031 Round robin: rr_mode = 1, req = 8'hFF held, done pulsed each grant -> grant_id sequence 7, 6, 5, 4, 3, 2, 1, 0, 7, starting after reset (last_id = 0, so the search starts at 7).
REQ-032 Timeout: MAX_HOLD = 16, single req[3] held, done never asserted -> grant_valid high for exactly 16 cycles, then timeout = 1 for one cycle with grant = 0, then grant to id 3 again.
REQ-033 Req drop and tie: req[2] deasserted on cycle 4 of its grant -> RELEASE next edge with timeout = 0; done and counter = MAX_HOLD on the same edge -> timeout = 0.
REQ-034 Reset mid-grant: rst = 1 while grant_id = 6 -> all outputs 0 on the next edge; after rst falls with req = 8'h40 and rr_mode = 1 -> grant_id = 6 (search from 7 wraps to 6).
